coverfloat_trace_packer: RTL
============================

# coverfloat_trace_packer

Parametrised capture-and-serialise block for floating-point coverage records. It accepts one DUT transaction per handshake (op, rounding mode, enable bits, exception flags, operands a/b/c, result) in any of the four supported formats. It buffers transactions in a DEPTH-entry FIFO and emits each one as a fixed-length burst of 32-bit words to the coverage/trace sink. It also keeps sticky exception flags and an emitted-record counter. It sits between the FPU monitor and the DPI reference/coverage collector, replacing per-format hard-wired capture.

## Interface
- FLEN, 32, operand width; legal values are 16, 32, 64 and 128.
- DEPTH, 4, FIFO depth in records; must be a power of two and at least 2.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  transaction present.
- in_ready  out  1  block can accept a transaction.
- in_op  in  32  op code, 1..13 (ADD=1 … CLASS=13).
- in_rm  in  32  rounding mode (0,1,2,3,4,6).
- in_enable  in  32  enable bits; bits [4:0] are used.
- in_flags  in  32  exception bits: [0] inexact, [1] underflow, [2] overflow, [3] infinite, [4] invalid.
- in_a, in_b, in_c, in_result  in  FLEN  operands and DUT result.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  sink accepts the word.
- out_data  out  32  serialised word.
- out_last  out  1  final word of the current record.
- occupancy  out  $clog2(DEPTH)+1  number of records stored, including the record being sent.
- sticky_flags  out  5  OR of in_flags[4:0] over all accepted records.
- clear_sticky  in  1  zeroes sticky_flags.
- rec_count  out  32  count of fully emitted records; wraps.

## Operation
- W = 1 when FLEN ≤ 32, otherwise FLEN/32. Words per record N = 1 + 4·W. For FLEN = 16, 32, 64 and 128 this gives N = 5, 5, 9 and 17.
- Word 0 is the header, with these fields:
  - [31:24] = 8'hCF.
  - [23:22] = fmt (16→0, 32→1, 64→2, 128→3).
  - [21:17] = flags[4:0].
  - [16:12] = enable[4:0].
  - [11:8] = rm[3:0].
  - [7:0] = op[7:0].
- After the header the words are a, b, c, result, each as W words, least-significant word first. For FLEN = 16 each operand is zero-extended to 32 bits.
- Accept: the FIFO stores the full record when in_valid && in_ready.
- in_ready = (occupancy < DEPTH). A pop in the same cycle does not open a slot while full; no full-cycle bypass.
- Serialiser FSM:
  - IDLE: FIFO is empty, out_valid = 0.
  - SEND: out_valid = 1 and out_data = word[idx] of the FIFO head.
  - On out_valid && out_ready: idx advances. At idx = N−1 (out_last = 1) the head is popped, idx returns to 0 and rec_count increments. The FSM goes to IDLE if the FIFO is then empty, otherwise it stays in SEND.
- out_data is stable while out_valid && !out_ready (AXI-style hold). out_valid never drops mid-record.
- Simultaneous push and pop: occupancy is unchanged and both take effect.
- sticky_flags is updated on accept with |= in_flags[4:0].
- If clear_sticky and an accept happen in the same cycle, the result equals the accepted record's flags only.
- in_op and in_rm values outside the legal set are passed through truncated; there is no checking.
- Reset takes effect immediately, including mid-record: the FIFO empties, idx = 0 and the partial record is discarded with no out_last.

## Timing
- Reset values: in_ready = 0 while rst_n = 0, then 1 in the first cycle after reset is released. out_valid = 0, out_data = 0, out_last = 0, occupancy = 0, sticky_flags = 0, rec_count = 0.
- Latency: a record accepted at edge t has its header on out_valid in cycle t+1.
- Throughput with out_ready held high: one word per cycle. Records are back-to-back with no bubble between out_last and the next header.
- in_ready deasserts in the cycle after occupancy reaches DEPTH. It reasserts in the cycle after the popping edge.
- occupancy, sticky_flags and rec_count are registered and reflect the previous edge.
- rec_count wraps from 32'hFFFFFFFF to 0 with no flag.

## Test plan
- FLEN=32, single ADD record: op=1, rm=0, flags=5'b00001, a=3F800000, b=40000000, c=0, result=40400000, out_ready=1.
  - Words: CF4201 header word 0xCF420001 | enable bits, then 3F800000, 40000000, 00000000, 40400000.
  - out_last is set on word 4 and rec_count becomes 1.
- FLEN=128, DEPTH=4: push 5 back-to-back records with out_ready=0.
  - in_ready is low after the 4th accept and the 5th record is held off.
  - Release out_ready: 68 words emitted, 17 per record, LSW first. Then the 5th record's 17 words follow.
- FLEN=16: a=16'h3C00.
  - First operand word is 0x00003C00 and fmt = 0.
  - Toggle out_ready randomly; out_data must hold whenever the word is stalled.
- Sticky flags: accept records with flags 0x02 then 0x10, giving sticky = 0x12.
  - Assert clear_sticky together with accepting a record with flags 0x04; sticky = 0x04.
- Full-boundary simultaneous push/pop: with DEPTH=2 full and the last word of the head being popped, in_valid=1 is not accepted that cycle and is accepted the next cycle. occupancy goes 2→1→2.
- Reset mid-record: drop rst_n after word 2 of a FLEN=64 record.
  - Next cycle: out_valid = 0, occupancy = 0, rec_count unchanged at 0.
  - A new record afterwards starts with a header word.

Source files
------------

// File: rtl/coverfloat_trace_packer.sv
// coverfloat_trace_packer
//   Captures one floating-point DUT transaction per handshake, buffers it in a
//   DEPTH-entry record FIFO, and serialises each record as a fixed burst of
//   N = 1 + 4*W 32-bit words (header, then a, b, c, result, each W words,
//   least-significant word first). Also keeps sticky exception flags and a
//   wrapping count of fully emitted records.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid / in_ready        transaction handshake
//   in_op, in_rm, in_enable,
//   in_flags                   header fields (low bits used)
//   in_a, in_b, in_c, in_result  FLEN-wide operands and result
//   out_valid / out_ready      word handshake to the trace sink
//   out_data, out_last         serialised word, final word of a record
//   occupancy                  records held, including the one being sent
//   sticky_flags, clear_sticky accumulated exception flags and their clear
//   rec_count                  fully emitted records (wraps)
module coverfloat_trace_packer #(
  parameter int FLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_op,
  input  logic [31:0]                in_rm,
  input  logic [31:0]                in_enable,
  input  logic [31:0]                in_flags,
  input  logic [FLEN-1:0]            in_a,
  input  logic [FLEN-1:0]            in_b,
  input  logic [FLEN-1:0]            in_c,
  input  logic [FLEN-1:0]            in_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [4:0]                 sticky_flags,
  input  logic                       clear_sticky,
  output logic [31:0]                rec_count
);

  localparam int W    = (FLEN <= 32) ? 1 : FLEN / 32;
  localparam int N    = 1 + 4 * W;
  localparam int OPW  = 32 * W;
  localparam int RECW = 32 * N;
  localparam int AW   = $clog2(DEPTH);
  localparam int IW   = $clog2(N);

  localparam logic [1:0] FMT = (FLEN == 16) ? 2'd0 :
                               (FLEN == 32) ? 2'd1 :
                               (FLEN == 64) ? 2'd2 : 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   OCC_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   OCC_FULL = (AW + 1)'(DEPTH);

  // Header word: tag, format, flags, enables, rounding mode, op.
  function automatic logic [31:0] make_header(
    input logic [31:0] op,
    input logic [31:0] rm,
    input logic [31:0] en,
    input logic [31:0] fl
  );
    return {8'hCF, FMT, fl[4:0], en[4:0], rm[3:0], op[7:0]};
  endfunction

  // Selects word idx of a flattened record (word 0 in the low 32 bits).
  function automatic logic [31:0] word_sel(
    input logic [RECW-1:0] rec,
    input logic [IW-1:0]   idx
  );
    logic [31:0] w;
    w = 32'b0;
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k)) begin
        w = rec[k*32 +: 32];
      end
    end
    return w;
  endfunction

  logic [RECW-1:0] mem_r [DEPTH];
  logic [AW-1:0]   rd_ptr_r, wr_ptr_r;
  logic [AW:0]     occ_r;
  logic [IW-1:0]   idx_r;
  logic [0:0]      state_r;
  logic            in_ready_r;
  logic [31:0]     out_data_r;
  logic            out_last_r;
  logic [4:0]      sticky_r;
  logic [31:0]     rec_count_r;

  logic            push_s, fire_s, pop_s;
  logic [AW:0]     occ_next_s;
  logic [AW-1:0]   rd_next_s, wr_next_s;
  logic [IW-1:0]   idx_next_s;
  logic [RECW-1:0] in_rec_s, head_next_s;
  logic [4:0]      sticky_next_s;
  logic [31:0]     rec_count_next_s;

  logic unused_bits;
  assign unused_bits = ^{in_op[31:8], in_rm[31:4], in_enable[31:5], in_flags[31:5]};

  // Operands are zero-extended to whole words (only matters for FLEN = 16).
  assign in_rec_s = {OPW'(in_result), OPW'(in_c), OPW'(in_b), OPW'(in_a),
                     make_header(in_op, in_rm, in_enable, in_flags)};

  // Handshake decode and next-state computation for FIFO, index and counters.
  always_comb begin
    push_s = in_valid && in_ready_r;
    fire_s = (state_r == ST_SEND) && out_ready;
    pop_s  = fire_s && (idx_r == LAST_IDX);

    case ({push_s, pop_s})
      2'b10:   occ_next_s = occ_r + OCC_ONE;
      2'b01:   occ_next_s = occ_r - OCC_ONE;
      default: occ_next_s = occ_r;
    endcase

    if (pop_s) begin
      rd_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_next_s = rd_ptr_r;
    end

    if (push_s) begin
      wr_next_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_next_s = wr_ptr_r;
    end

    if (pop_s) begin
      idx_next_s = '0;
    end else if (fire_s) begin
      idx_next_s = idx_r + IDX_ONE;
    end else begin
      idx_next_s = idx_r;
    end

    // A push landing in the slot that becomes the head (FIFO empty after
    // this edge's pop) is not yet in mem_r, so forward it directly. The
    // pointers can also be equal when full, but then no push is possible.
    if (push_s && (wr_ptr_r == rd_next_s)) begin
      head_next_s = in_rec_s;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end

    if (clear_sticky) begin
      if (push_s) begin
        sticky_next_s = in_flags[4:0];
      end else begin
        sticky_next_s = 5'b0;
      end
    end else if (push_s) begin
      sticky_next_s = sticky_r | in_flags[4:0];
    end else begin
      sticky_next_s = sticky_r;
    end

    if (pop_s) begin
      rec_count_next_s = rec_count_r + 32'd1;
    end else begin
      rec_count_next_s = rec_count_r;
    end
  end

  // Record storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_rec_s;
    end
  end

  // Control state and registered outputs; out_data is precomputed from the
  // next head and index so it holds naturally while the sink stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      occ_r       <= '0;
      idx_r       <= '0;
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      out_data_r  <= 32'b0;
      out_last_r  <= 1'b0;
      sticky_r    <= 5'b0;
      rec_count_r <= 32'b0;
    end else begin
      rd_ptr_r    <= rd_next_s;
      wr_ptr_r    <= wr_next_s;
      occ_r       <= occ_next_s;
      idx_r       <= idx_next_s;
      in_ready_r  <= (occ_next_s < OCC_FULL);
      sticky_r    <= sticky_next_s;
      rec_count_r <= rec_count_next_s;
      if (occ_next_s != '0) begin
        state_r    <= ST_SEND;
        out_data_r <= word_sel(head_next_s, idx_next_s);
        out_last_r <= (idx_next_s == LAST_IDX);
      end else begin
        state_r    <= ST_IDLE;
        out_data_r <= 32'b0;
        out_last_r <= 1'b0;
      end
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = (state_r == ST_SEND);
  assign out_data     = out_data_r;
  assign out_last     = out_last_r;
  assign occupancy    = occ_r;
  assign sticky_flags = sticky_r;
  assign rec_count    = rec_count_r;

endmodule
